fft_peak_finder: RTL and testbench
==================================

// Module: fft_peak_finder
// PURPOSE
//  Streaming peak-bin detector between the FFT core and the BCD/display divider.
//  Takes one complex FFT bin per valid beat and computes |X|^2 = re^2 + im^2.
//  Tracks the largest bin in the search window and, per frame, outputs peak index,
//  peak magnitude and tone frequency in Hz. Replaces the combinational scan with
//  a pipelined, frame-aware engine.
// PARAMETERS
//  LOG2N    10    log2 of FFT size; N = 2**LOG2N
//  FS       1000  sampling frequency in Hz (unsigned, < 2**32)
//  BIN_MIN  1     lowest bin searched (1 excludes DC)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  bin_real   in   16     signed real part of current bin
//  bin_imag   in   16     signed imaginary part of current bin
//  bin_valid  in   1      beat qualifier; no backpressure, every valid beat consumed
//  bin_last   in   1      marks final bin of a frame; sampled only with bin_valid
//  peak_bin   out  LOG2N  index of peak bin of the last completed frame
//  peak_mag   out  32     unsigned re^2+im^2 of the peak bin
//  freq       out  32     (peak_bin*FS) >> LOG2N, truncated
//  done       out  1      1-cycle pulse: outputs updated for a new frame
//  frame_err  out  1      valid with done: frame length != N
// BEHAVIOUR
//  - Sync active-high reset: all outputs 0, bin counter 0, pipeline flushed.
//  - Reset mid-frame discards that frame; no done for it.
//  - Bin counter (LOG2N bits) increments per valid beat; the beat's index is its
//    counter value. Counter returns to 0 after a frame end.
//  - Frame end is either:
//    - bin_last=1; or
//    - counter == N-1 without bin_last. This beat closes the frame with
//      frame_err=1; the next beat starts a new frame.
//  - bin_last at count != N-1 gives frame_err=1.
//  - Search window is BIN_MIN <= idx <= N/2-1. Other bins are counted only.
//  - Arithmetic:
//    - Squares are 32-bit unsigned; sum max 2**31 ((-32768)^2 * 2), no overflow.
//    - freq uses a 32xLOG2N product of at least 32+LOG2N bits, then >>LOG2N.
//  - Pipeline, 3 stages; valid/first/last/idx/in-window flags travel with data:
//    - S1: register re^2, im^2.
//    - S2: sum; compare against running max.
//    - S3: register outputs; pulse done.
//  - Running max is loaded with (mag=0, idx=BIN_MIN) at each frame's first beat.
//  - Update uses strict >, so on a tie the lowest index wins.
//  - An all-zero frame gives peak_bin=BIN_MIN, peak_mag=0.
//  - Latency: last beat sampled at edge k gives done=1 in the cycle after edge k+3.
//    peak_bin/peak_mag/freq change on that same edge and hold until the next done.
//  - Gaps (bin_valid=0) stall nothing and do not advance the counter.
//  - Back-to-back frames: next frame's first beat may arrive at edge k+1.
//    Per-frame reset of the running max travels with S2 data, so frames never mix.
//  - FSM (counter side):
//    - IDLE -> ACCUM on first valid beat.
//    - ACCUM -> IDLE on frame end, or directly into the next frame if a beat follows.
// TESTING (LOG2N=4, FS=1000, BIN_MIN=1 unless noted)
//  1. Bin 3 = (1000,0), all others 0, last at idx 15 -> peak_bin=3,
//     peak_mag=1000000, freq=187, frame_err=0; done exactly 3 edges after last.
//  2. Bins 2 and 5 = (100,100) -> peak_bin=2, peak_mag=20000 (tie to lowest).
//  3. Bin0=(30000,0), bin12=(30000,0), bin4=(10,-10) -> peak_bin=4,
//     peak_mag=200 (DC and upper half ignored).
//  4. Bin 6 = (-32768,-32768) -> peak_mag=32'h80000000, peak_bin=6, freq=375.
//  5. Timing cases:
//     - bin_last at idx 9 -> done with frame_err=1.
//     - Then a back-to-back full frame, random valid gaps, peak at bin 7
//       -> frame_err=0, peak_bin=7, freq=437.
//  6. Reset cases:
//     - rst pulsed at idx 7 -> no done, outputs 0.
//     - A following full frame with peak bin 5 -> peak_bin=5, freq=312.

Source files
------------

// File: rtl/fft_peak_finder_if.sv
// Bin stream in / per-frame peak result out, shared between the FFT side and the
// peak finder.
interface fft_peak_finder_if #(
  parameter int unsigned LOG2N = 10
);
  logic signed [15:0] bin_real;
  logic signed [15:0] bin_imag;
  logic               bin_valid;
  logic               bin_last;
  logic [LOG2N-1:0]   peak_bin;
  logic [31:0]        peak_mag;
  logic [31:0]        freq;
  logic               done;
  logic               frame_err;

  modport master (
    output bin_real, bin_imag, bin_valid, bin_last,
    input  peak_bin, peak_mag, freq, done, frame_err
  );

  modport slave (
    input  bin_real, bin_imag, bin_valid, bin_last,
    output peak_bin, peak_mag, freq, done, frame_err
  );
endinterface

// File: rtl/fft_peak_finder.sv
// Streaming peak-bin detector: |X|^2 per bin, largest bin in the search window
// per frame, reported with its index, magnitude and tone frequency.
module fft_peak_finder #(
  parameter int unsigned LOG2N   = 10,
  parameter int unsigned FS      = 1000,
  parameter int unsigned BIN_MIN = 1
) (
  input  logic            clk,
  input  logic            rst,
  fft_peak_finder_if.slave bus
);
  localparam int unsigned N  = 1 << LOG2N;
  localparam int unsigned FW = 32 + LOG2N;
  localparam logic [LOG2N-1:0] IDX_LO = LOG2N'(BIN_MIN);
  localparam logic [LOG2N-1:0] IDX_HI = LOG2N'(N / 2 - 1);

  typedef enum logic {ST_IDLE, ST_ACCUM} state_t;

  state_t           r_state, w_state_nxt;
  logic [LOG2N-1:0] r_cnt, w_cnt_nxt;
  logic             w_first, w_frame_end, w_err, w_inwin;

  // stage 0: registered input beat with its frame tags
  logic               r_s0_vld, r_s0_first, r_s0_end, r_s0_err, r_s0_win;
  logic [LOG2N-1:0]   r_s0_idx;
  logic signed [15:0] r_s0_re, r_s0_im;
  // stage 1: squares
  logic               r_s1_vld, r_s1_first, r_s1_end, r_s1_err, r_s1_win;
  logic [LOG2N-1:0]   r_s1_idx;
  logic [31:0]        r_s1_re_sq, r_s1_im_sq;
  // stage 2: running max
  logic [31:0]        r_max_mag;
  logic [LOG2N-1:0]   r_max_idx;
  logic               r_s2_end, r_s2_err;

  logic signed [31:0] w_re_ext, w_im_ext, w_re_sq, w_im_sq;
  logic [31:0]        w_sum, w_base_mag;
  logic [LOG2N-1:0]   w_base_idx;
  logic [FW-1:0]      w_prod;
  logic [31:0]        w_freq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // IDLE always coincides with counter 0, so IDLE marks a frame's first beat
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_frame_end = 1'b0;
    w_err       = 1'b0;
    w_first     = (r_state == ST_IDLE);
    w_inwin     = (r_cnt >= IDX_LO) && (r_cnt <= IDX_HI);
    if (bus.bin_valid) begin
      w_frame_end = bus.bin_last || (r_cnt == '1);
      w_err       = w_frame_end && !(bus.bin_last && (r_cnt == '1));
      if (w_frame_end) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_state_nxt = ST_ACCUM;
        w_cnt_nxt   = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_vld   <= 1'b0;
      r_s0_first <= 1'b0;
      r_s0_end   <= 1'b0;
      r_s0_err   <= 1'b0;
      r_s0_win   <= 1'b0;
      r_s0_idx   <= '0;
      r_s0_re    <= '0;
      r_s0_im    <= '0;
    end else begin
      r_s0_vld   <= bus.bin_valid;
      r_s0_first <= bus.bin_valid && w_first;
      r_s0_end   <= w_frame_end;
      r_s0_err   <= w_err;
      r_s0_win   <= w_inwin;
      r_s0_idx   <= r_cnt;
      r_s0_re    <= bus.bin_real;
      r_s0_im    <= bus.bin_imag;
    end
  end

  always_comb begin
    w_re_ext = 32'(r_s0_re);
    w_im_ext = 32'(r_s0_im);
    w_re_sq  = w_re_ext * w_re_ext;
    w_im_sq  = w_im_ext * w_im_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_end   <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_win   <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_re_sq <= '0;
      r_s1_im_sq <= '0;
    end else begin
      r_s1_vld   <= r_s0_vld;
      r_s1_first <= r_s0_first;
      r_s1_end   <= r_s0_vld && r_s0_end;
      r_s1_err   <= r_s0_err;
      r_s1_win   <= r_s0_win;
      r_s1_idx   <= r_s0_idx;
      r_s1_re_sq <= $unsigned(w_re_sq);
      r_s1_im_sq <= $unsigned(w_im_sq);
    end
  end

  // first beat compares against a fresh (0, BIN_MIN) so frames never mix
  always_comb begin
    w_sum      = r_s1_re_sq + r_s1_im_sq;
    w_base_mag = r_s1_first ? '0 : r_max_mag;
    w_base_idx = r_s1_first ? IDX_LO : r_max_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_max_mag <= '0;
      r_max_idx <= IDX_LO;
      r_s2_end  <= 1'b0;
      r_s2_err  <= 1'b0;
    end else begin
      r_s2_end <= r_s1_vld && r_s1_end;
      r_s2_err <= r_s1_err;
      if (r_s1_vld) begin
        if (r_s1_win && (w_sum > w_base_mag)) begin
          r_max_mag <= w_sum;
          r_max_idx <= r_s1_idx;
        end else begin
          r_max_mag <= w_base_mag;
          r_max_idx <= w_base_idx;
        end
      end
    end
  end

  always_comb begin
    w_prod = FW'(FS) * FW'(r_max_idx);
    w_freq = 32'(w_prod >> LOG2N);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.peak_bin  <= '0;
      bus.peak_mag  <= '0;
      bus.freq      <= '0;
      bus.done      <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.done <= r_s2_end;
      if (r_s2_end) begin
        bus.peak_bin  <= r_max_idx;
        bus.peak_mag  <= r_max_mag;
        bus.freq      <= w_freq;
        bus.frame_err <= r_s2_err;
      end
    end
  end
endmodule

// File: tb/tb_fft_peak_finder.sv
// Self-checking bench for fft_peak_finder with a per-frame reference model.
module tb_fft_peak_finder;
  localparam int unsigned LOG2N   = 4;
  localparam int unsigned N       = 16;
  localparam int unsigned FS      = 1000;
  localparam int unsigned BIN_MIN = 1;

  typedef struct {
    logic [63:0] cyc;
    logic [63:0] pbin;
    logic [63:0] mag;
    logic [63:0] freq;
    logic [63:0] err;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_peak_finder_if #(.LOG2N(LOG2N)) bus();

  fft_peak_finder #(.LOG2N(LOG2N), .FS(FS), .BIN_MIN(BIN_MIN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   re_a[N];
  int   im_a[N];
  rec_t q[$];
  rec_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      rec_t r;
      r.cyc  = 64'(cyc);
      r.pbin = {60'b0, bus.peak_bin};
      r.mag  = {32'b0, bus.peak_mag};
      r.freq = {32'b0, bus.freq};
      r.err  = {63'b0, bus.frame_err};
      q.push_back(r);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic clear_bins();
    for (int i = 0; i < N; i++) begin
      re_a[i] = 0;
      im_a[i] = 0;
    end
  endtask

  task automatic idle_inputs();
    bus.bin_valid = 1'b0;
    bus.bin_last  = 1'b0;
    bus.bin_real  = '0;
    bus.bin_imag  = '0;
  endtask

  // Drives one frame from re_a/im_a and queues what the frame should report.
  task automatic drive(input int len, input int gapmax, input bit use_last);
    longint mx;
    longint m;
    int     pk;
    int     last_cyc;
    rec_t   e;
    mx = 0;
    pk = BIN_MIN;
    last_cyc = 0;
    for (int i = 0; i < len; i++) begin
      if (i >= int'(BIN_MIN) && i <= int'(N / 2 - 1)) begin
        m = longint'(re_a[i]) * re_a[i] + longint'(im_a[i]) * im_a[i];
        if (m > mx) begin
          mx = m;
          pk = i;
        end
      end
    end
    for (int i = 0; i < len; i++) begin
      int g;
      g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
      repeat (g) begin
        idle_inputs();
        @(posedge clk); #1;
      end
      bus.bin_valid = 1'b1;
      bus.bin_last  = use_last && (i == len - 1);
      bus.bin_real  = 16'(re_a[i]);
      bus.bin_imag  = 16'(im_a[i]);
      @(posedge clk); #1;
      last_cyc = cyc;
    end
    idle_inputs();
    e.cyc  = 64'(last_cyc + 3);
    e.pbin = 64'(pk);
    e.mag  = 64'(mx);
    e.freq = 64'((longint'(pk) * FS) >> LOG2N);
    e.err  = (use_last && len == int'(N)) ? 64'd0 : 64'd1;
    exp_q.push_back(e);
  endtask

  task automatic check_pending(input string tag);
    rec_t e;
    rec_t a;
    int   w;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      w = 0;
      while (q.size() == 0 && w < 12) begin
        @(negedge clk); #1;
        w++;
      end
      if (q.size() == 0) begin
        chk({tag, "_done_timeout"}, 64'(q.size()), 64'd1);
      end else begin
        a = q.pop_front();
        chk({tag, "_latency"}, a.cyc,  e.cyc);
        chk({tag, "_bin"},     a.pbin, e.pbin);
        chk({tag, "_mag"},     a.mag,  e.mag);
        chk({tag, "_freq"},    a.freq, e.freq);
        chk({tag, "_err"},     a.err,  e.err);
      end
    end
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_extra_done"}, 64'(q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bin",  {60'b0, bus.peak_bin}, 64'd0);
    chk("rst_mag",  {32'b0, bus.peak_mag}, 64'd0);
    chk("rst_freq", {32'b0, bus.freq},     64'd0);
    chk("rst_done", {63'b0, bus.done},     64'd0);
    chk("rst_err",  {63'b0, bus.frame_err}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // single tone
    clear_bins();
    re_a[3] = 1000;
    drive(16, 0, 1'b1);
    check_pending("t1");

    // tie goes to the lower index
    clear_bins();
    re_a[2] = 100; im_a[2] = 100;
    re_a[5] = 100; im_a[5] = 100;
    drive(16, 0, 1'b1);
    check_pending("t2");

    // DC and upper half excluded
    clear_bins();
    re_a[0] = 30000;
    re_a[12] = 30000;
    re_a[4] = 10; im_a[4] = -10;
    drive(16, 0, 1'b1);
    check_pending("t3");

    // largest possible magnitude
    clear_bins();
    re_a[6] = -32768; im_a[6] = -32768;
    drive(16, 0, 1'b1);
    check_pending("t4");

    // all-zero frame
    clear_bins();
    drive(16, 1, 1'b1);
    check_pending("t_zero");

    // short frame then a back-to-back full frame with gaps
    clear_bins();
    re_a[2] = 40;
    drive(10, 0, 1'b1);
    for (int i = 0; i < N; i++) begin
      re_a[i] = int'($urandom_range(40, 0)) - 20;
      im_a[i] = int'($urandom_range(40, 0)) - 20;
    end
    re_a[7] = 500;
    drive(16, 3, 1'b1);
    check_pending("t5");

    // frame closed by the counter wrap without bin_last
    clear_bins();
    re_a[5] = 77;
    drive(16, 0, 1'b0);
    check_pending("t_wrap");

    // reset mid-frame: beat 7 is sampled together with rst
    clear_bins();
    re_a[2] = 999;
    for (int i = 0; i < 8; i++) begin
      bus.bin_valid = 1'b1;
      bus.bin_last  = 1'b0;
      bus.bin_real  = 16'(re_a[i]);
      bus.bin_imag  = 16'(im_a[i]);
      if (i == 7) rst = 1'b1;
      @(posedge clk); #1;
    end
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("t6_no_done", 64'(q.size()), 64'd0);
    chk("t6_bin",  {60'b0, bus.peak_bin}, 64'd0);
    chk("t6_mag",  {32'b0, bus.peak_mag}, 64'd0);
    chk("t6_freq", {32'b0, bus.freq},     64'd0);

    clear_bins();
    re_a[5] = 2000; im_a[5] = -3;
    re_a[3] = 1999;
    drive(16, 0, 1'b1);
    check_pending("t6");

    // random frames, small values provoke ties
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) begin
        if (f < 3) begin
          re_a[i] = int'($urandom_range(8, 0)) - 4;
          im_a[i] = int'($urandom_range(8, 0)) - 4;
        end else begin
          re_a[i] = int'($urandom_range(65535, 0)) - 32768;
          im_a[i] = int'($urandom_range(65535, 0)) - 32768;
        end
      end
      drive(16, f % 3, 1'b1);
    end
    check_pending("rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
